// File: rtl/v_regfile_mp_pkg.sv
// Shared defaults and state encoding for the multi-port vector register file.
package v_regfile_mp_pkg;

    localparam int DEF_VLEN = 256;
    localparam int DEF_ELEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } vrf_state_e;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/v_regfile_mp_sb.sv
// Busy-bit scoreboard: one reservation bit per vector register.
module v_regfile_sb
    import v_regfile_mp_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    localparam int AW  = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_next;

    // The set is applied after the clear so a reservation wins a same-register collision.
    always_comb begin
        busy_next = busy;
        if (enable) begin
            if (clr_en) busy_next[clr_addr] = 1'b0;
            if (set_en) busy_next[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

endmodule

// File: rtl/v_regfile_mp.sv
// Vector register file with N read ports, masked writes, clear-on-reset sequencer and scoreboard.
// Define VRF_BYPASS_EN to forward a same-cycle write into matching reads.
module v_regfile_mp
    import v_regfile_mp_pkg::*;
#(
    parameter int VLEN   = DEF_VLEN,
    parameter int ELEN   = DEF_ELEN,
    parameter int NREG   = DEF_NREG,
    parameter int NRD    = DEF_NRD,
    localparam int NELEM = VLEN / ELEN,
    localparam int AW    = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready_o,
    input  logic                wb_en_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [NELEM-1:0]    wb_mask_i,
    input  logic [VLEN-1:0]     wb_data_i,
    input  logic                wb_last_i,
    input  logic                rsv_en_i,
    input  logic [AW-1:0]       rsv_addr_i,
    input  logic [NRD-1:0]      rd_en_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*VLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    output logic [VLEN-1:0]     v0_o
);

    vrf_state_e      state;
    logic [AW-1:0]   clr_ptr;
    logic [VLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            ready;
    logic            wb_fire;

    assign ready   = (state == READY);
    assign ready_o = ready;
    assign wb_fire = ready & wb_en_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            if (clr_ptr == AW'(NREG - 1)) begin
                state   <= READY;
                clr_ptr <= '0;
            end else begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    // Storage has no reset of its own; the clear walk is the only way it gets zeroed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_ptr] <= '0;
            end else if (wb_en_i) begin
                for (int e = 0; e < NELEM; e++) begin
                    if (wb_mask_i[e]) regs[wb_addr_i][e*ELEN +: ELEN] <= wb_data_i[e*ELEN +: ELEN];
                end
            end
        end
    end

    function automatic logic [VLEN-1:0] read_reg(input logic [AW-1:0] addr);
        logic [VLEN-1:0] val;
        val = regs[addr];
`ifdef VRF_BYPASS_EN
        if (wb_fire && (wb_addr_i == addr)) begin
            for (int e = 0; e < NELEM; e++) begin
                if (wb_mask_i[e]) val[e*ELEN +: ELEN] = wb_data_i[e*ELEN +: ELEN];
            end
        end
`endif
        return val;
    endfunction

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ready && rd_en_i[p]) begin
                rd_data_o[p*VLEN +: VLEN] = read_reg(rd_addr_i[p*AW +: AW]);
                rd_busy_o[p]              = busy[rd_addr_i[p*AW +: AW]];
            end
        end
    end

    assign v0_o = ready ? regs[0] : '0;

    v_regfile_sb #(
        .NREG(NREG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .enable   (ready),
        .set_en   (rsv_en_i),
        .set_addr (rsv_addr_i),
        .clr_en   (wb_fire & wb_last_i),
        .clr_addr (wb_addr_i),
        .busy     (busy)
    );

endmodule

// File: tb/tb_v_regfile_mp.sv
// Self-checking bench for v_regfile_mp: directed scenarios then random traffic against a reference model.
module tb_v_regfile_mp;

    localparam int VLEN  = 128;
    localparam int ELEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 3;
    localparam int AW    = 5;
    localparam int NELEM = VLEN / ELEN;

    logic                clk;
    logic                rst;
    logic                ready_o;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [NELEM-1:0]    wb_mask;
    logic [VLEN-1:0]     wb_data;
    logic                wb_last;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*VLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic [VLEN-1:0]     v0_o;

    int checks   = 0;
    int failures = 0;

    logic [VLEN-1:0] m_reg [NREG];
    logic [NREG-1:0] m_busy;
    int              clr_left = -1;

    v_regfile_mp #(
        .VLEN(VLEN), .ELEN(ELEN), .NREG(NREG), .NRD(NRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ready_o    (ready_o),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_mask_i  (wb_mask),
        .wb_data_i  (wb_data),
        .wb_last_i  (wb_last),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .v0_o       (v0_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] merge(input logic [VLEN-1:0] old, input logic [VLEN-1:0] data,
                                              input logic [NELEM-1:0] mask);
        logic [VLEN-1:0] r;
        for (int e = 0; e < NELEM; e++) r[e*ELEN +: ELEN] = mask[e] ? data[e*ELEN +: ELEN] : old[e*ELEN +: ELEN];
        return r;
    endfunction

    task automatic check_output();
        logic            exp_ready;
        logic [AW-1:0]   a;
        logic [VLEN-1:0] exp_data;
        logic            exp_busy;
        exp_ready = (clr_left == 0);
        check("ready_o", ready_o, exp_ready);
        check("v0_o", v0_o, exp_ready ? m_reg[0] : '0);
        for (int p = 0; p < NRD; p++) begin
            a        = rd_addr[p*AW +: AW];
            exp_data = '0;
            exp_busy = 1'b0;
            if (exp_ready && rd_en[p]) begin
                exp_data = m_reg[a];
`ifdef VRF_BYPASS_EN
                if (wb_en && wb_addr == a) exp_data = merge(exp_data, wb_data, wb_mask);
`endif
                exp_busy = m_busy[a];
            end
            check($sformatf("rd_data[%0d]", p), rd_data_o[p*VLEN +: VLEN], exp_data);
            check($sformatf("rd_busy[%0d]", p), rd_busy_o[p], exp_busy);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            clr_left = NREG;
            m_busy   = '0;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) foreach (m_reg[i]) m_reg[i] = '0;
        end else if (clr_left == 0) begin
            if (wb_en) begin
                m_reg[wb_addr] = merge(m_reg[wb_addr], wb_data, wb_mask);
                if (wb_last) m_busy[wb_addr] = 1'b0;
            end
            if (rsv_en) m_busy[rsv_addr] = 1'b1;
        end
    endtask

    task automatic step();
        #1;
        if (clr_left >= 0) check_output();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic we, input logic [AW-1:0] wa, input logic [NELEM-1:0] wm,
                                  input logic [VLEN-1:0] wd, input logic wl);
        wb_en   = we;
        wb_addr = wa;
        wb_mask = wm;
        wb_data = wd;
        wb_last = wl;
    endtask

    task automatic set_idle();
        apply_stimulus(1'b0, '0, '0, '0, 1'b0);
        rsv_en   = 1'b0;
        rsv_addr = '0;
        rd_en    = '0;
        rd_addr  = '0;
    endtask

    task automatic set_read(input int p, input logic [AW-1:0] a);
        rd_en[p]          = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wait_ready(input string tag, input int during_write_at);
        int low;
        low = 0;
        while (ready_o !== 1'b1 && low < 100) begin
            rd_en   = '1;
            rd_addr = {5'd31, 5'd1, 5'd0};
            if (low == during_write_at) apply_stimulus(1'b1, 5'd1, 4'hF, '1, 1'b0);
            else                       apply_stimulus(1'b0, '0, '0, '0, 1'b0);
            step();
            low++;
        end
        check(tag, low, 32);
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        wait_ready("ready_low_after_reset", -1);

        // masked write into v3
        apply_stimulus(1'b1, 5'd3, 4'hF, '1, 1'b0);
        step();
        apply_stimulus(1'b1, 5'd3, 4'b0101, 128'h44444444_33333333_22222222_11111111, 1'b0);
        step();
        set_idle();
        set_read(0, 5'd3);
        #1;
        check("masked_write_v3", rd_data_o[127:0], 128'hFFFFFFFF_33333333_FFFFFFFF_11111111);
        step();

        // v0 is writable and drives v0_o
        apply_stimulus(1'b1, 5'd0, 4'hF, '1, 1'b0);
        step();
        set_idle();
        set_read(2, 5'd0);
        #1;
        check("v0_o_all_ones", v0_o, {VLEN{1'b1}});
        check("port2_reads_v0", rd_data_o[2*VLEN +: VLEN], {VLEN{1'b1}});
        step();

        // same-cycle write and read of v5
        apply_stimulus(1'b1, 5'd5, 4'hF, {4{32'h55555555}}, 1'b0);
        step();
        apply_stimulus(1'b1, 5'd5, 4'b0001, 128'hA, 1'b0);
        set_read(1, 5'd5);
        #1;
`ifdef VRF_BYPASS_EN
        check("bypass_elem0", rd_data_o[VLEN +: ELEN], 32'hA);
`else
        check("bypass_elem0", rd_data_o[VLEN +: ELEN], 32'h55555555);
`endif
        step();
        set_idle();
        set_read(1, 5'd5);
        step();

        // scoreboard on v7
        set_read(0, 5'd7);
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        step();
        rsv_en = 1'b0;
        #1;
        check("busy_v7_t1", rd_busy_o[0], 1'b1);
        step();
        step();
        apply_stimulus(1'b1, 5'd7, 4'h0, '0, 1'b1);
        step();
        apply_stimulus(1'b0, '0, '0, '0, 1'b0);
        #1;
        check("busy_v7_t4", rd_busy_o[0], 1'b0);
        step();
        rsv_en = 1'b1;
        apply_stimulus(1'b1, 5'd7, 4'h0, '0, 1'b1);
        step();
        rsv_en = 1'b0;
        apply_stimulus(1'b0, '0, '0, '0, 1'b0);
        #1;
        check("busy_v7_set_wins", rd_busy_o[0], 1'b1);
        step();

        // reset pulse in the middle of the clear walk
        apply_stimulus(1'b1, 5'd1, 4'hF, {4{32'hDEADBEEF}}, 1'b0);
        step();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("ready_low_after_midclear", 25);
        set_read(0, 5'd1);
        #1;
        check("write_during_clear_lost", rd_data_o[127:0], 128'h0);
        step();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply_stimulus($urandom_range(0, 1), AW'($urandom_range(0, NREG - 1)), NELEM'($urandom),
                           {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0));
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = AW'($urandom_range(0, NREG - 1));
            rd_en    = NRD'($urandom);
            for (int p = 0; p < NRD; p++)
                rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? wb_addr : AW'($urandom_range(0, NREG - 1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
